// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch front end.
package fetch_pkg;

    localparam int DEF_IW = 16;
    localparam int DEF_AW = 16;

    localparam logic [DEF_IW-1:0] NOP = '0;

    typedef struct packed {
        logic [DEF_IW-1:0] instr;
        logic [DEF_AW-1:0] pc;
    } fetch_entry_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction buffer: FETCH_W-wide enqueue, 0..FETCH_W dequeue, flush,
// FETCH_W combinational read lanes starting at head.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int IW      = DEF_IW,
    parameter int AW      = DEF_AW,
    parameter int FETCH_W = 2,
    parameter int QDEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          enq,
    input  logic [FETCH_W*IW-1:0]         enq_instr,
    input  logic [FETCH_W*AW-1:0]         enq_pc,
    input  logic [clog2(FETCH_W+1)-1:0]   deq_count,
    output logic [FETCH_W-1:0]            lane_valid,
    output logic [FETCH_W*IW-1:0]         lane_instr,
    output logic [FETCH_W*AW-1:0]         lane_pc,
    output logic [clog2(QDEPTH+1)-1:0]    count
);

    localparam int PW = clog2(QDEPTH);
    localparam int CW = clog2(QDEPTH+1);

    logic [IW-1:0] instr_mem [QDEPTH];
    logic [AW-1:0] pc_mem    [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] deq_req;
    logic [CW-1:0] eff_deq;
    logic [CW-1:0] enq_n;

    // Over-asking by decode is clamped to what is actually held.
    always_comb begin
        deq_req = CW'(deq_count);
        eff_deq = (deq_req > count) ? count : deq_req;
        enq_n   = enq ? CW'(FETCH_W) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                for (int i = 0; i < FETCH_W; i++) begin
                    instr_mem[tail + PW'(i)] <= enq_instr[i*IW +: IW];
                    pc_mem[tail + PW'(i)]    <= enq_pc[i*AW +: AW];
                end
                tail <= tail + PW'(FETCH_W);
            end
            head  <= head + PW'(eff_deq);
            count <= count + enq_n - eff_deq;
        end
    end

    // Stale slots past count stay in storage; lanes beyond count read as NOP/0.
    always_comb begin
        lane_valid = '0;
        lane_instr = '0;
        lane_pc    = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            if (count > CW'(i)) begin
                lane_valid[i]          = 1'b1;
                lane_instr[i*IW +: IW] = instr_mem[head + PW'(i)];
                lane_pc[i*AW +: AW]    = pc_mem[head + PW'(i)];
            end else begin
                lane_instr[i*IW +: IW] = IW'(NOP);
            end
        end
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// N-wide fetch front end: PC, request credit and in-flight tracking around
// fetch_queue; redirects flush the queue and squash the outstanding response.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int            IW       = DEF_IW,
    parameter int            AW       = DEF_AW,
    parameter int            FETCH_W  = 2,
    parameter int            QDEPTH   = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          redirect_valid,
    input  logic [AW-1:0]                 redirect_pc,
    input  logic [clog2(FETCH_W+1)-1:0]   deq_count,
    output logic                          imem_req,
    output logic [AW-1:0]                 imem_addr,
    input  logic [FETCH_W*IW-1:0]         imem_rdata,
    output logic [FETCH_W-1:0]            out_valid,
    output logic [FETCH_W*IW-1:0]         out_instr,
    output logic [FETCH_W*AW-1:0]         out_pc,
    output logic [clog2(QDEPTH+1)-1:0]    queue_count
);

    logic [AW-1:0]         pc;
    logic [AW-1:0]         req_pc;
    logic                  inflight;
    logic                  enq;
    logic [FETCH_W*AW-1:0] enq_pc;

    // imem contract: imem_req in cycle t returns FETCH_W words in imem_rdata in
    // t+1 with no backpressure, so a request is only made when the queue has room
    // for both the outstanding group and the new one.
    always_comb begin
        imem_req  = !reset && !redirect_valid &&
                    ((QDEPTH - int'(queue_count)) >= (FETCH_W * (1 + int'(inflight))));
        imem_addr = pc;
        enq       = inflight && !redirect_valid;
        enq_pc    = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            enq_pc[i*AW +: AW] = req_pc + AW'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
        end else if (imem_req) begin
            req_pc   <= pc;
            pc       <= pc + AW'(FETCH_W);
            inflight <= 1'b1;
        end else begin
            inflight <= 1'b0;
        end
    end

    fetch_queue #(
        .IW      (IW),
        .AW      (AW),
        .FETCH_W (FETCH_W),
        .QDEPTH  (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .enq        (enq),
        .enq_instr  (imem_rdata),
        .enq_pc     (enq_pc),
        .deq_count  (deq_count),
        .lane_valid (out_valid),
        .lane_instr (out_instr),
        .lane_pc    (out_pc),
        .count      (queue_count)
    );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: queue-based reference model, randomized redirects
// and decode consumption, plus literal anchor points.
module tb_fetch_queue_unit;
    import fetch_pkg::*;

    localparam int IW = 16;
    localparam int AW = 16;
    localparam int FW = 2;
    localparam int QD = 8;
    localparam int DW = clog2(FW+1);
    localparam int CW = clog2(QD+1);

    // clock / reset
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic               redirect_valid = 1'b0;
    logic [AW-1:0]      redirect_pc    = '0;
    logic [DW-1:0]      deq_count      = '0;
    logic               imem_req;
    logic [AW-1:0]      imem_addr;
    logic [FW*IW-1:0]   imem_rdata     = '0;
    logic [FW-1:0]      out_valid;
    logic [FW*IW-1:0]   out_instr;
    logic [FW*AW-1:0]   out_pc;
    logic [CW-1:0]      queue_count;

    fetch_queue_unit #(
        .IW (IW), .AW (AW), .FETCH_W (FW), .QDEPTH (QD), .RESET_PC ('0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .deq_count      (deq_count),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .queue_count    (queue_count)
    );

    function automatic logic [IW-1:0] word_at(input logic [AW-1:0] a);
        return a ^ 16'hC300;
    endfunction

    // synchronous instruction memory
    always @(posedge clk) begin
        if (imem_req) begin
            for (int i = 0; i < FW; i++) imem_rdata[i*IW +: IW] <= word_at(imem_addr + AW'(i));
        end
    end

    // reference model state
    fetch_entry_t  exp_q[$];
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_req_pc;
    bit            m_infl;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_req(input bit rv);
        return !rv && ((QD - exp_q.size()) >= FW * (1 + int'(m_infl)));
    endfunction

    task automatic compare_all();
        logic [FW-1:0]    ev;
        logic [FW*IW-1:0] ei;
        logic [FW*AW-1:0] ep;
        ev = '0;
        ei = '0;
        ep = '0;
        for (int i = 0; i < FW; i++) begin
            if (i < exp_q.size()) begin
                ev[i]          = 1'b1;
                ei[i*IW +: IW] = exp_q[i].instr;
                ep[i*AW +: AW] = exp_q[i].pc;
            end
        end
        check("imem_req",    imem_req,    model_req(redirect_valid));
        check("imem_addr",   imem_addr,   m_pc);
        check("out_valid",   out_valid,   ev);
        check("out_instr",   out_instr,   ei);
        check("out_pc",      out_pc,      ep);
        check("queue_count", queue_count, exp_q.size());
    endtask

    task automatic model_edge(input bit rv, input logic [AW-1:0] rpc, input int dq);
        bit           req;
        int           eff;
        fetch_entry_t e;
        req = model_req(rv);
        if (rv) begin
            exp_q.delete();
            m_pc   = rpc;
            m_infl = 1'b0;
        end else begin
            eff = (dq < exp_q.size()) ? dq : exp_q.size();
            repeat (eff) void'(exp_q.pop_front());
            if (m_infl) begin
                for (int i = 0; i < FW; i++) begin
                    e.pc    = m_req_pc + AW'(i);
                    e.instr = word_at(e.pc);
                    exp_q.push_back(e);
                end
            end
            if (req) begin
                m_req_pc = m_pc;
                m_pc     = m_pc + AW'(FW);
                m_infl   = 1'b1;
            end else begin
                m_infl = 1'b0;
            end
        end
    endtask

    // driver: one clock cycle per call, starting and ending 1 time unit after an edge
    task automatic step(input bit rv, input logic [AW-1:0] rpc, input int dq);
        redirect_valid = rv;
        redirect_pc    = rpc;
        deq_count      = DW'(dq);
        #1;
        compare_all();
        @(posedge clk);
        model_edge(rv, rpc, dq);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        deq_count      = '0;
        #1;
        check("rst_imem_req",    imem_req,    1'b0);
        check("rst_imem_addr",   imem_addr,   16'h0000);
        check("rst_out_valid",   out_valid,   2'b00);
        check("rst_out_instr",   out_instr,   32'h0);
        check("rst_out_pc",      out_pc,      32'h0);
        check("rst_queue_count", queue_count, 4'd0);
        exp_q.delete();
        m_pc     = '0;
        m_req_pc = '0;
        m_infl   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        do_reset();

        // streaming at full throughput
        step(0, '0, 2);
        step(0, '0, 2);
        check("lit_valid_c2", out_valid, 2'b11);
        check("lit_pc_c2",    out_pc,    32'h0001_0000);
        check("lit_instr_c2", out_instr, 32'hC301_C300);
        step(0, '0, 2);
        check("lit_pc_c3",    out_pc,    32'h0003_0002);

        // decode stalls: queue fills, head lanes hold
        repeat (8) step(0, '0, 0);
        check("lit_full_count", queue_count, 4'd8);
        check("lit_full_pc",    out_pc,      32'h0003_0002);
        repeat (10) step(0, '0, 2);

        // redirect with a response outstanding
        step(1, 16'h0040, 2);
        check("lit_redir_count", queue_count, 4'd0);
        check("lit_redir_addr",  imem_addr,   16'h0040);
        step(0, '0, 2);
        step(0, '0, 2);
        check("lit_redir_pc", out_pc, 32'h0041_0040);

        // alternating consumption wraps head
        for (int i = 0; i < 20; i++) step(0, '0, (i % 2) + 1);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 19) == 0, AW'($urandom), $urandom_range(0, FW));
        end

        // asynchronous reset in the middle of a stream
        step(1, 16'h0100, 0);
        repeat (4) step(0, '0, 0);
        check("lit_pre_reset_count", queue_count, 4'd6);
        do_reset();
        repeat (6) step(0, '0, 2);
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 29) == 0, AW'($urandom), $urandom_range(0, FW));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised N-wide instruction fetch front end; successor to the fixed 2-wide fetch stage.
- Issues FETCH_W-wide requests to a synchronous instruction memory and buffers the returned instructions, with their PCs, in a QDEPTH circular queue.
- Presents up to FETCH_W instructions per cycle to decode, which consumes a variable count (0..FETCH_W).
- Branch redirects flush the queue and squash in-flight fetches; sits between imem and decode.

Parameters:
- IW, 16, instruction width in bits
- AW, 16, PC/address width (word-addressed)
- FETCH_W, 2, instructions fetched and offered per cycle
- QDEPTH, 8, queue entries; power of two, >= 2*FETCH_W
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- redirect_valid  in  1  branch taken / redirect this cycle
- redirect_pc  in  AW  redirect target
- deq_count  in  clog2(FETCH_W+1)  instructions decode accepts this cycle (0 = stall)
- imem_req  out  1  fetch request valid
- imem_addr  out  AW  address of first instruction in the group
- imem_rdata  in  FETCH_W*IW  words addr..addr+FETCH_W-1; valid exactly one cycle after imem_req
- out_valid  out  FETCH_W  lane i valid
- out_instr  out  FETCH_W*IW  lane i = queue[head+i]; 0 (NOP) when invalid
- out_pc  out  FETCH_W*AW  PC of lane i; 0 when invalid
- queue_count  out  clog2(QDEPTH+1)  occupied entries

Behaviour:
- Reset, asynchronous:
  - pc=RESET_PC, head=tail=count=0, inflight=0.
  - All queue storage cleared to 0.
  - imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
  - Reset asserted mid-operation discards everything, including an in-flight response.
- Request rule, combinational from registered state:
  - imem_req = !redirect_valid && (QDEPTH - count) >= FETCH_W*(1+inflight).
  - imem_addr = pc.
  - On request: pc <= pc + FETCH_W, mod 2^AW (wraps silently), and inflight <= 1; otherwise inflight <= 0.
- Response: in the cycle after a request, if inflight=1 and redirect_valid=0, enqueue FETCH_W entries {imem_rdata lane i, pc_of_request+i} at tail, lane 0 first.
- Latency: request in cycle t, response in t+1, out_valid visible in t+2.
- Full throughput: one request per cycle when decode consumes FETCH_W per cycle.
- Output lanes: out_valid[i] = (count > i). Lane i is a combinational read of entry head+i mod QDEPTH.
- Dequeue:
  - eff_deq = min(deq_count, count); decode over-asking is clamped, never underflows.
  - head <= head + eff_deq.
  - Dequeued slots keep their stale data, which is masked by out_valid.
- Simultaneous enqueue and dequeue: count_next = count + enq_n - eff_deq, where enq_n is 0 or FETCH_W. The request rule guarantees no overflow; full state is reached with no data loss.
- Redirect has priority over dequeue, enqueue and request in the same cycle:
  - At the edge: head=tail=count=0, pc=redirect_pc, inflight=0.
  - Any response arriving in the redirect cycle is dropped.
  - First request is issued in the cycle after the redirect.
- Consecutive redirects: the last one wins; no request is issued while redirect_valid=1.
- Pointers are log2(QDEPTH) bits and wrap naturally; count is tracked separately, so full/empty are unambiguous.
- deq_count=0 with an empty queue: no-op.

Decomposition:
- fetch_pkg holds:
  - NOP constant (0)
  - IW/AW defaults
  - fetch entry struct {instr, pc}
  - clog2 helper function
- Sub-module fetch_queue: circular buffer with FETCH_W-wide enqueue, variable 0..FETCH_W dequeue, flush input, FETCH_W read lanes and count output.
- The top level holds the pc, inflight and request/credit logic.

Test Plan:
- Reset release, imem returns pc-indexed words, deq_count=2 every cycle -> imem_req high every cycle from cycle 0 (addr 0,2,4...); out_valid=2'b11 from cycle 2; lanes show instr[0],[1] then [2],[3]; out_pc 0/1, 2/3.
- deq_count=0 held -> queue fills to 8 and imem_req drops once free < 4; out lanes hold instr[0],[1]; release with deq=2 -> order preserved, no lost or duplicated PCs.
- redirect_valid with redirect_pc=0x40 while a response is in flight -> that response is dropped; queue_count=0 next cycle; next imem_addr=0x40; first valid out_pc=0x40/0x41.
- deq_count=1 alternating with 2 over 20 cycles -> head wraps past QDEPTH; PCs strictly consecutive; queue_count never exceeds 8.
- deq_count=2 with queue_count=1 -> eff_deq=1, count becomes 0, no underflow; lane 1 out_instr=0.
- reset asserted mid-stream with queue_count=6 -> all outputs 0 immediately (async); after release, fetch restarts at RESET_PC.
- Parameter sweep FETCH_W=4, QDEPTH=16 -> same checks; 4 lanes valid at full throughput.
